// File: rtl/uart_transmitter.sv
// UART transmitter: one character per valid/ready handshake, serialised on tx_o.
// Bit timing comes only from the oversampling tick; OV_RATE ticks make one bit period.
module uart_transmitter #(
    parameter int OV_RATE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ov_baud_rt_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    output logic       ready_o,
    input  logic [1:0] data_bits_i,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    input  logic       stop_bits_i,
    output logic       tx_o,
    output logic       tx_done_o
);

    localparam int TW = $clog2(OV_RATE);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  tick_cnt, tick_cnt_nxt;
    logic [2:0]     bit_cnt, bit_cnt_nxt;
    logic [7:0]     shift_reg, shift_nxt;
    logic [2:0]     last_data, last_data_nxt;
    logic           par_en, par_en_nxt;
    logic           par_bit, par_bit_nxt;
    logic           two_stop, two_stop_nxt;
    logic           tx_nxt;
    logic           bit_end;
    logic [7:0]     data_masked;

    assign ready_o     = (state == IDLE);
    assign bit_end     = (state != IDLE) && ov_baud_rt_i && (tick_cnt == TW'(OV_RATE - 1));
    assign data_masked = data_i & (8'hFF >> (3'd3 - {1'b0, data_bits_i}));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            last_data <= '0;
            par_en    <= 1'b0;
            par_bit   <= 1'b0;
            two_stop  <= 1'b0;
            tx_o      <= 1'b1;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            last_data <= last_data_nxt;
            par_en    <= par_en_nxt;
            par_bit   <= par_bit_nxt;
            two_stop  <= two_stop_nxt;
            tx_o      <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        last_data_nxt = last_data;
        par_en_nxt    = par_en;
        par_bit_nxt   = par_bit;
        two_stop_nxt  = two_stop;
        tx_nxt        = tx_o;
        tx_done_o     = 1'b0;

        // Counter sits at zero while idle so every frame starts on a fresh bit period.
        if (state == IDLE) begin
            tick_cnt_nxt = '0;
        end else if (ov_baud_rt_i) begin
            tick_cnt_nxt = bit_end ? '0 : tick_cnt + 1'b1;
        end else begin
            tick_cnt_nxt = tick_cnt;
        end

        case (state)
            IDLE: begin
                if (data_valid_i) begin
                    shift_nxt     = data_masked;
                    last_data_nxt = {1'b0, data_bits_i} + 3'd4;
                    par_en_nxt    = parity_en_i;
                    par_bit_nxt   = (^data_masked) ^ parity_odd_i;
                    two_stop_nxt  = stop_bits_i;
                    bit_cnt_nxt   = '0;
                    tx_nxt        = 1'b0;
                    state_nxt     = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_nxt      = shift_reg[0];
                    bit_cnt_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift_reg >> 1;
                    if (bit_cnt == last_data) begin
                        bit_cnt_nxt = '0;
                        if (par_en) begin
                            tx_nxt    = par_bit;
                            state_nxt = PARITY;
                        end else begin
                            tx_nxt    = 1'b1;
                            state_nxt = STOP;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        tx_nxt      = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_nxt      = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    if (bit_cnt == {2'b00, two_stop}) begin
                        tx_done_o   = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
